seq_det_ctrl: RTL
=================

// Module: seq_det_ctrl
// PURPOSE
//  Run-controlled, programmable serial pattern detector. Generalises the fixed 11011 Moore detector.
//  Pattern, length, overlap mode and match limit are loaded through a config port.
//  Start/stop arm and disarm detection; matches are counted and flagged.
//  Sits between the serial bit source and the consumer of match events/counts.
// PARAMETERS
//  MAXLEN  8  maximum pattern length in bits (>=2)
//  CNTW    8  width of match counter and match limit
// PORTS
//  clk          in   1                      clock, all logic rising-edge
//  rst          in   1                      synchronous, active-high reset
//  cfg_we       in   1                      config write strobe
//  cfg_pattern  in   MAXLEN                 pattern; bit[len-1] is first-received bit
//  cfg_len      in   $clog2(MAXLEN+1)       pattern length, legal 1..MAXLEN
//  cfg_overlap  in   1                      1 = overlapping detection, 0 = non-overlapping
//  cfg_limit    in   CNTW                   matches before auto-stop; 0 = unlimited
//  start        in   1                      arm detector (pulse)
//  stop         in   1                      disarm detector (pulse)
//  in_valid     in   1                      serial bit valid this cycle
//  in           in   1                      serial data bit
//  out          out  1                      match pulse, registered (Moore)
//  busy         out  1                      1 while RUN
//  done         out  1                      1 after limit reached, until next start/rst
//  match_count  out  CNTW                   matches in current/last run, saturating
// BEHAVIOUR
//  Reset: state=IDLE; out/busy/done=0; match_count=0; history=0; fill=0.
//   Config reset: pattern=5'b11011 (zero-extended), len=5, overlap=0, limit=0.
//  States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE).
//  cfg_we: accepted only in IDLE/DONE; ignored in RUN.
//   Write with cfg_len==0 or >MAXLEN is discarded entirely; all cfg fields are kept.
//  start in IDLE/DONE: RUN next cycle. Clears history, fill, match_count, done.
//   cfg_we+start same cycle: new config written and used by the run.
//   start in RUN is ignored.
//  RUN, in_valid=1: hist_n={hist[MAXLEN-2:0],in}; fill_n=min(fill+1,len).
//   match = (fill_n==len) && (hist_n[len-1:0]==pattern[len-1:0]).
//   On match: out=1 in the following cycle (exactly 1-cycle pulse).
//   On match: match_count++ (saturating at all-ones).
//   On match, non-overlap: fill reset to 0; overlap: fill held at len.
//  RUN, in_valid=0: no shift, no match; out=0 next cycle.
//  Limit: if limit!=0 and the match makes count==limit, go to DONE next cycle (out still pulses).
//   Bits arriving in DONE/IDLE are ignored; out=0.
//  stop in RUN: IDLE next cycle, done=0, match_count retained.
//   Same-cycle match is still counted and pulsed. stop+limit hit same cycle: DONE wins.
//   stop outside RUN: no effect.
//  rst at any time (incl. mid-run): full reset incl. config defaults, pending out dropped.
// TESTING
//  1 Defaults, start, bits 1,1,0,1,1,1,1,0,1,1 (valid each cycle)
//    -> out pulses after bit5 and bit10; count=2.
//  2 overlap=1, len=5, pattern 11011, bits 1,1,0,1,1,0,1,1
//    -> pulses after bit5 and bit8; count=2 (non-overlap gives 1).
//  3 limit=2, three non-overlapping 11011 occurrences
//    -> DONE after 2nd pulse, busy=0, done=1, third ignored, count=2.
//  4 Test 1 stream with in_valid=0 between every bit
//    -> same 2 pulses, each 1 cycle after its final valid bit.
//  5 In RUN, cfg_we len=3 ignored. After stop: cfg_len=0 ignored, then len=3/pattern 101, start.
//    -> bits 1,0,1,0,1 non-overlap gives 1 match.
//  6 rst after 3 bits of 11011 -> outputs 0, config defaults; stop coincident with match -> pulse+count, then IDLE.

Source files
------------

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl
// Description : Run-controlled programmable serial pattern detector with
//               match counting, optional auto-stop limit and overlap mode.
// Revision    : 1.0
// ============================================================================
module seq_det_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [MAXLEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAXLEN+1)-1:0] cfg_len,
    input  logic                        cfg_overlap,
    input  logic [CNTW-1:0]             cfg_limit,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        in_valid,
    input  logic                        in,
    output logic                        out,
    output logic                        busy,
    output logic                        done,
    output logic [CNTW-1:0]             match_count
);

    localparam int                LW            = $clog2(MAXLEN + 1);
    localparam logic [MAXLEN-1:0] C_DEF_PATTERN = MAXLEN'(5'b11011);
    localparam logic [LW-1:0]     C_DEF_LEN     = LW'(5);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_n;
    logic [MAXLEN-1:0]   r_hist,  w_hist_n;
    logic [LW-1:0]       r_fill,  w_fill_n;
    logic [CNTW-1:0]     r_cnt,   w_cnt_n;
    logic                r_out,   w_out_n;
    logic [MAXLEN-1:0]   r_pat,   w_pat_n;
    logic [LW-1:0]       r_len,   w_len_n;
    logic                r_ovl,   w_ovl_n;
    logic [CNTW-1:0]     r_lim,   w_lim_n;

    logic [MAXLEN-1:0]   w_shift;
    logic [MAXLEN-1:0]   w_mask;
    logic [LW-1:0]       w_fill_inc;
    logic [CNTW-1:0]     w_cnt_inc;
    logic                w_match;
    logic                w_cfg_ok;

    assign w_shift    = {r_hist[MAXLEN-2:0], in};
    assign w_mask     = ~({MAXLEN{1'b1}} << r_len);
    assign w_fill_inc = (r_fill >= r_len) ? r_len : r_fill + LW'(1);
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNTW'(1);
    // Only the newest len bits are compared; fill guards against stale history
    assign w_match    = (w_fill_inc == r_len) && (((w_shift ^ r_pat) & w_mask) == '0);
    assign w_cfg_ok   = cfg_we && (cfg_len != '0) && (cfg_len <= LW'(MAXLEN));

    always_comb begin
        w_state_n = r_state;
        w_hist_n  = r_hist;
        w_fill_n  = r_fill;
        w_cnt_n   = r_cnt;
        w_out_n   = 1'b0;
        w_pat_n   = r_pat;
        w_len_n   = r_len;
        w_ovl_n   = r_ovl;
        w_lim_n   = r_lim;
        case (r_state)
            S_RUN: begin
                if (in_valid) begin
                    w_hist_n = w_shift;
                    w_fill_n = w_fill_inc;
                    if (w_match) begin
                        w_out_n  = 1'b1;
                        w_cnt_n  = w_cnt_inc;
                        w_fill_n = r_ovl ? r_len : '0;
                    end
                end
                // Reaching the limit takes priority over a coincident stop
                if (in_valid && w_match && (r_lim != '0) && (w_cnt_inc == r_lim)) begin
                    w_state_n = S_DONE;
                end else if (stop) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                if (w_cfg_ok) begin
                    w_pat_n = cfg_pattern;
                    w_len_n = cfg_len;
                    w_ovl_n = cfg_overlap;
                    w_lim_n = cfg_limit;
                end
                if (start) begin
                    w_state_n = S_RUN;
                    w_hist_n  = '0;
                    w_fill_n  = '0;
                    w_cnt_n   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_pat   <= C_DEF_PATTERN;
            r_len   <= C_DEF_LEN;
            r_ovl   <= 1'b0;
            r_lim   <= '0;
        end else begin
            r_state <= w_state_n;
            r_hist  <= w_hist_n;
            r_fill  <= w_fill_n;
            r_cnt   <= w_cnt_n;
            r_out   <= w_out_n;
            r_pat   <= w_pat_n;
            r_len   <= w_len_n;
            r_ovl   <= w_ovl_n;
            r_lim   <= w_lim_n;
        end
    end

    assign out         = r_out;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign match_count = r_cnt;

endmodule
`default_nettype wire
